// File: rtl/regwr_arbiter.sv
// regwr_arbiter: round-robin arbiter sharing the register-file write port among NREQ requesters.
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       synchronous active-low reset
//   req_valid_i  per-requester write request
//   req_addr_i   destination register, requester i at [i*AW +: AW]
//   req_data_i   write data, requester i at [i*DW +: DW]
//   req_ready_o  one-hot accept (valid & ready on an edge = transfer)
//   hold_i       register-file stall, blocks all grants
//   loadsel_o    load select to decoder, 6'd32 when idle
//   wr_en_o      write strobe accompanying loadsel_o/wr_data_o
//   wr_data_o    write data to the register file
//   grant_id_o   requester whose write is on the output
//   wr_count_o   committed write count, saturating
module regwr_arbiter #(
    parameter int NREQ = 3,
    parameter int DW   = 32,
    parameter int AW   = 5
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NREQ-1:0]    req_valid_i,
    input  logic [NREQ*AW-1:0] req_addr_i,
    input  logic [NREQ*DW-1:0] req_data_i,
    output logic [NREQ-1:0]    req_ready_o,
    input  logic               hold_i,
    output logic [5:0]         loadsel_o,
    output logic               wr_en_o,
    output logic [DW-1:0]      wr_data_o,
    output logic [1:0]         grant_id_o,
    output logic [15:0]        wr_count_o
);
    logic [1:0]    rr_q, rr_d, gnt, gid_q, gid_d;
    logic          found, wr_en_q, wr_en_d;
    logic [5:0]    ls_q, ls_d;
    logic [DW-1:0] wd_q, wd_d;
    logic [15:0]   cnt_q, cnt_d;

    // Ready looks only at valid, pointer, hold and reset so grants run back-to-back.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req_valid_i[(int'(rr_q) + k) % NREQ]) begin
                found = 1'b1;
                gnt   = 2'((int'(rr_q) + k) % NREQ);
            end
        end
        if (!rst_ni || hold_i) found = 1'b0;
    end

    assign req_ready_o = found ? NREQ'(1) << gnt : '0;

    always_comb begin
        wr_en_d = found;
        ls_d    = found ? {1'b0, req_addr_i[gnt*AW +: AW]} : 6'd32;
        wd_d    = found ? req_data_i[gnt*DW +: DW] : wd_q;
        gid_d   = found ? gnt : gid_q;
        rr_d    = !found ? rr_q : (gnt == 2'(NREQ - 1)) ? 2'd0 : gnt + 2'd1;
        cnt_d   = (wr_en_q && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_q    <= '0;
            wr_en_q <= 1'b0;
            ls_q    <= 6'd32;
            wd_q    <= '0;
            gid_q   <= '0;
            cnt_q   <= '0;
        end else begin
            rr_q    <= rr_d;
            wr_en_q <= wr_en_d;
            ls_q    <= ls_d;
            wd_q    <= wd_d;
            gid_q   <= gid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign loadsel_o  = ls_q;
    assign wr_en_o    = wr_en_q;
    assign wr_data_o  = wd_q;
    assign grant_id_o = gid_q;
    assign wr_count_o = cnt_q;
endmodule
